// File: rtl/lap_memory_pkg.sv
// ============================================================================
// Module : lap_memory_pkg
// Brief  : Shared widths and controller state encoding for the lap store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lap_memory_pkg;

    localparam int EPOCH_W = 18;
    localparam int MSEC_W  = 10;
    localparam int LAP_W   = EPOCH_W + MSEC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage : lap_memory_pkg

`default_nettype wire

// File: rtl/lap_ram.sv
// ============================================================================
// Module : lap_ram
// Brief  : Simple dual-port RAM, synchronous write, registered 1-cycle read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lap_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 28
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // No reset on storage so the array maps onto block/distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : lap_ram

`default_nettype wire

// File: rtl/lap_memory.sv
// ============================================================================
// Module : lap_memory
// Brief  : Lap-time store: saves stopwatch time, replays laps, clears RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lap_memory
    import lap_memory_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               save,
    input  logic               retrieve,
    input  logic               clear,
    input  logic [EPOCH_W-1:0] epoch,
    input  logic [MSEC_W-1:0]  m_epoch,
    output logic               busy,
    output logic [EPOCH_W-1:0] lap_epoch,
    output logic [MSEC_W-1:0]  lap_m_epoch,
    output logic [AW-1:0]      lap_index,
    output logic               lap_valid,
    output logic [AW:0]        lap_count,
    output logic               full,
    output logic               overflow
);

    localparam logic [AW:0]   C_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST_SLOT = AW'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_clr_ptr;
    logic [AW:0]        r_lap_count;
    logic               r_overflow;
    logic               r_lap_valid;
    logic [EPOCH_W-1:0] r_lap_epoch;
    logic [MSEC_W-1:0]  r_lap_m_epoch;
    logic [AW-1:0]      r_lap_index;

    logic               w_full;
    logic               w_ram_we;
    logic [AW-1:0]      w_ram_waddr;
    logic [LAP_W-1:0]   w_ram_wdata;
    logic               w_ram_re;
    logic [LAP_W-1:0]   w_ram_rdata;

    assign w_full = (r_lap_count == C_DEPTH_CNT);

    lap_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (LAP_W)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command priority in IDLE is clear > save > retrieve; a save against a
    // full store is consumed (flags overflow) rather than passed to retrieve.
    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        w_ram_waddr  = r_wr_ptr;
        w_ram_wdata  = {epoch, m_epoch};
        w_ram_re     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_state_next = ST_CLEAR;
                end else if (save) begin
                    if (!w_full) begin
                        w_ram_we     = 1'b1;
                        w_state_next = ST_WRITE;
                    end
                end else if (retrieve && (r_lap_count != '0)) begin
                    w_ram_re     = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                w_state_next = ST_IDLE;
            end
            ST_READ: begin
                w_state_next = ST_IDLE;
            end
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_ptr;
                w_ram_wdata = '0;
                if (r_clr_ptr == C_LAST_SLOT) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_clr_ptr     <= '0;
            r_lap_count   <= '0;
            r_overflow    <= 1'b0;
            r_lap_valid   <= 1'b0;
            r_lap_epoch   <= '0;
            r_lap_m_epoch <= '0;
            r_lap_index   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (clear) begin
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                        r_clr_ptr     <= '0;
                        r_lap_count   <= '0;
                        r_overflow    <= 1'b0;
                        r_lap_valid   <= 1'b0;
                        r_lap_epoch   <= '0;
                        r_lap_m_epoch <= '0;
                        r_lap_index   <= '0;
                    end else if (save && w_full) begin
                        r_overflow <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wr_ptr    <= r_wr_ptr + AW'(1);
                    r_lap_count <= r_lap_count + (AW+1)'(1);
                end
                ST_READ: begin
                    r_lap_epoch   <= w_ram_rdata[LAP_W-1:MSEC_W];
                    r_lap_m_epoch <= w_ram_rdata[MSEC_W-1:0];
                    r_lap_index   <= r_rd_ptr;
                    r_lap_valid   <= 1'b1;
                    // Wrap on the current count so laps saved since the last
                    // retrieve join the replay cycle.
                    if ({1'b0, r_rd_ptr} == (r_lap_count - (AW+1)'(1))) begin
                        r_rd_ptr <= '0;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                end
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + AW'(1);
                end
                default: begin
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign lap_epoch   = r_lap_epoch;
    assign lap_m_epoch = r_lap_m_epoch;
    assign lap_index   = r_lap_index;
    assign lap_valid   = r_lap_valid;
    assign lap_count   = r_lap_count;
    assign full        = w_full;
    assign overflow    = r_overflow;

endmodule : lap_memory

`default_nettype wire

// File: tb/tb_lap_memory.sv
// ============================================================================
// Module : tb_lap_memory
// Brief  : Self-checking bench for lap_memory: vector table plus scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lap_memory;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        save, retrieve, clear;
    logic [17:0] epoch;
    logic [9:0]  m_epoch;
    logic        busy;
    logic [17:0] lap_epoch;
    logic [9:0]  lap_m_epoch;
    logic [2:0]  lap_index;
    logic        lap_valid;
    logic [3:0]  lap_count;
    logic        full;
    logic        overflow;

    lap_memory #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .save        (save),
        .retrieve    (retrieve),
        .clear       (clear),
        .epoch       (epoch),
        .m_epoch     (m_epoch),
        .busy        (busy),
        .lap_epoch   (lap_epoch),
        .lap_m_epoch (lap_m_epoch),
        .lap_index   (lap_index),
        .lap_valid   (lap_valid),
        .lap_count   (lap_count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        s, r, c;
        logic [17:0] e;
        logic [9:0]  ms;
        int          busy_cyc;
        int          cnt;
        logic        full;
        logic        ovf;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [17:0] e;
        logic [9:0]  ms;
        logic [2:0]  idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [27:0] m_mem [DEPTH];
    int          m_cnt, m_wr, m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic c,
                       input logic [17:0] e, input logic [9:0] ms,
                       input int b, input int cnt, input logic f,
                       input logic o, input logic v);
        vec_t x;
        x.s = s; x.r = r; x.c = c; x.e = e; x.ms = ms;
        x.busy_cyc = b; x.cnt = cnt; x.full = f; x.ovf = o; x.valid = v;
        vecs.push_back(x);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wr = 0; m_rd = 0;
        sb.delete();
    endtask

    task automatic model_apply(input logic s, input logic r, input logic c,
                               input logic [17:0] e, input logic [9:0] ms);
        exp_t x;
        if (c) begin
            m_cnt = 0; m_wr = 0; m_rd = 0;
        end else if (s) begin
            if (m_cnt < DEPTH) begin
                m_mem[m_wr] = {e, ms};
                m_wr = (m_wr + 1) % DEPTH;
                m_cnt++;
            end
        end else if (r && m_cnt > 0) begin
            x.e   = m_mem[m_rd][27:10];
            x.ms  = m_mem[m_rd][9:0];
            x.idx = 3'(m_rd);
            sb.push_back(x);
            m_rd = (m_rd == m_cnt - 1) ? 0 : m_rd + 1;
        end
    endtask

    // One-edge command pulse; returns number of busy cycles that follow.
    task automatic pulse(input logic s, input logic r, input logic c,
                         input logic [17:0] e, input logic [9:0] ms, output int n);
        @(negedge clock);
        save = s; retrieve = r; clear = c; epoch = e; m_epoch = ms;
        @(posedge clock);
        #1;
        save = 1'b0; retrieve = 1'b0; clear = 1'b0;
        model_apply(s, r, c, e, ms);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_pop();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("lap_epoch", 32'(lap_epoch), 32'(x.e));
            chk("lap_m_epoch", 32'(lap_m_epoch), 32'(x.ms));
            chk("lap_index", 32'(lap_index), 32'(x.idx));
        end
    endtask

    initial begin
        int n;
        logic [17:0] ea, eb, ec;
        reset = 1'b1; save = 0; retrieve = 0; clear = 0; epoch = '0; m_epoch = '0;
        model_reset();

        ea = {6'd4, 6'd5, 6'd6};
        eb = {6'd10, 6'd20, 6'd30};
        ec = {6'd23, 6'd59, 6'd59};
        add(1,0,0, {6'd1,6'd2,6'd3}, 10'd456, 1, 1, 0, 0, 0);
        add(0,1,0, '0, '0, 1, 1, 0, 0, 1);
        add(0,0,1, '0, '0, 8, 0, 0, 0, 0);
        add(1,0,0, ea, 10'd7,   1, 1, 0, 0, 0);
        add(1,0,0, eb, 10'd500, 1, 2, 0, 0, 0);
        add(1,0,0, ec, 10'd999, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0,1,0, '0, '0, 1, 3, 0, 0, 1);
        add(0,0,1, '0, '0, 8, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            add(1,0,0, {6'(i), 6'(i+10), 6'(i+20)}, 10'(100+i),
                (i <= 8) ? 1 : 0, (i <= 8) ? i : 8, i >= 8, i == 9, 0);
        add(0,1,0, '0, '0, 1, 8, 1, 1, 1);
        add(0,0,1, '0, '0, 8, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add(1,0,0, {6'(i), 6'(2*i), 6'(3*i)}, 10'(900+i), 1, i, 0, 0, 0);
        add(0,0,1, '0, '0, 8, 0, 0, 0, 0);
        add(0,1,0, '0, '0, 0, 0, 0, 0, 0);
        add(1,0,1, ec, 10'd1, 8, 0, 0, 0, 0);

        #22;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(lap_count), 0);
        chk("reset_valid", 32'(lap_valid), 0);
        chk("reset_ovf", 32'(overflow), 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            pulse(vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].e, vecs[i].ms, n);
            chk($sformatf("v%0d_busy", i), 32'(n), 32'(vecs[i].busy_cyc));
            chk($sformatf("v%0d_count", i), 32'(lap_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_valid", i), 32'(lap_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                check_pop();
            end else begin
                chk($sformatf("v%0d_zero", i),
                    {1'b0, lap_epoch, lap_m_epoch, lap_index}, 32'd0);
            end
        end
        chk("sb_drained", 32'(sb.size()), 0);

        // Save pulsed during the CLEAR busy window is dropped.
        pulse(1,0,0, ea, 10'd1, n);
        pulse(1,0,0, eb, 10'd2, n);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        model_apply(0,0,1, '0, '0);
        n = busy ? 1 : 0;
        @(negedge clock);
        save = 1'b1; epoch = ec; m_epoch = 10'd3;
        @(posedge clock); #1;
        save = 1'b0;
        while (busy && n < 20) begin
            n++;
            @(posedge clock); #1;
        end
        chk("drop_busy", 32'(n), 8);
        chk("drop_count", 32'(lap_count), 0);

        // Async reset in the 3rd cycle of CLEAR.
        pulse(1,0,0, ea, 10'd9, n);
        pulse(0,1,0, '0, '0, n);
        check_pop();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); @(posedge clock); #2;
        chk("rst_mid_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_outs", {lap_valid, lap_count, full, overflow, lap_index}, 32'd0);
        chk("rst_mid_lap", {4'd0, lap_epoch, lap_m_epoch}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        pulse(1,0,0, eb, 10'd77, n);
        chk("post_rst_busy", 32'(n), 1);
        chk("post_rst_count", 32'(lap_count), 1);
        pulse(0,1,0, '0, '0, n);
        chk("post_rst_valid", 32'(lap_valid), 1);
        check_pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_lap_memory

`default_nettype wire
